// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
package spi_pkg;

   localparam int unsigned SPI_WIDTH = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus a delayed copy for rise/fall detection.
module sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sync_q;
   logic dly_q;

   // Synchronizer chain; reset value sets the idle level seen by edge detection
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta   <= RST_VAL;
         sync_q <= RST_VAL;
         dly_q  <= RST_VAL;
      end else begin
         meta   <= din;
         sync_q <= meta;
         dly_q  <= sync_q;
      end
   end

   assign sync = sync_q;
   assign rise = sync_q & ~dly_q;
   assign fall = ~sync_q & dly_q;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder, fully oversampled in the system clock domain.
module spi_responder
   import spi_pkg::*;
#(
   parameter int unsigned WIDTH = SPI_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sclk,
   input  logic             cs_n,
   input  logic             mosi,
   output logic             miso,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             tx_underrun,
   output logic             frame_abort
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic sclk_s, sclk_rise, sclk_fall;
   logic cs_s, cs_rise, cs_fall;
   logic mosi_s, mosi_rise, mosi_fall;
   logic unused_mosi_edges;

   sync_edge #(.RST_VAL(1'b0)) u_sclk (
      .clock(clock), .reset(reset), .din(sclk),
      .sync(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
   );

   sync_edge #(.RST_VAL(1'b1)) u_cs (
      .clock(clock), .reset(reset), .din(cs_n),
      .sync(cs_s), .rise(cs_rise), .fall(cs_fall)
   );

   sync_edge #(.RST_VAL(1'b0)) u_mosi (
      .clock(clock), .reset(reset), .din(mosi),
      .sync(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
   );

   assign unused_mosi_edges = sclk_s ^ cs_s ^ mosi_rise ^ mosi_fall;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
   logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic             empty_q, empty_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             underrun_q, underrun_d;
   logic             abort_q, abort_d;
   logic             miso_q, miso_d;
   logic             load;

   // Next-state: FSM, bit counter, shift registers, shadow handshake, pulses
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      shadow_d   = shadow_q;
      empty_d    = empty_q;
      done_d     = done_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      underrun_d = 1'b0;
      abort_d    = 1'b0;
      load       = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d  = '0;
            done_d = 1'b0;
            if (cs_fall) begin
               state_d = SHIFT;
               load    = 1'b1;
            end
         end
         SHIFT: begin
            if (cs_rise) begin
               // Deselect wins over any coincident sclk edge
               state_d = IDLE;
               cnt_d   = '0;
               done_d  = 1'b0;
               if (cnt_q != '0) abort_d = 1'b1;
            end else if (sclk_rise) begin
               rx_sh_d = {rx_sh_q[WIDTH-2:0], mosi_s};
               if (cnt_q == CW'(WIDTH - 1)) begin
                  cnt_d      = '0;
                  rx_data_d  = rx_sh_d;
                  rx_valid_d = 1'b1;
                  done_d     = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (sclk_fall) begin
               if (cnt_q != '0) begin
                  tx_sh_d = tx_sh_q << 1;
               end else if (done_q) begin
                  load = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Frame load sees the shadow as it was before any same-cycle offer
      if (load) begin
         if (!empty_q) begin
            tx_sh_d = shadow_q;
            empty_d = 1'b1;
         end else begin
            tx_sh_d    = '0;
            underrun_d = 1'b1;
         end
      end

      if (tx_valid && empty_q) begin
         shadow_d = tx_data;
         empty_d  = 1'b0;
      end

      miso_d = (state_d == SHIFT) ? tx_sh_d[WIDTH-1] : 1'b0;
   end

   // State and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         shadow_q   <= '0;
         empty_q    <= 1'b1;
         done_q     <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         underrun_q <= 1'b0;
         abort_q    <= 1'b0;
         miso_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         shadow_q   <= shadow_d;
         empty_q    <= empty_d;
         done_q     <= done_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         underrun_q <= underrun_d;
         abort_q    <= abort_d;
         miso_q     <= miso_d;
      end
   end

   assign miso        = miso_q;
   assign tx_ready    = empty_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign tx_underrun = underrun_q;
   assign frame_abort = abort_q;

endmodule
